// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Serial-to-bus bridge. A host sends command packets over an 8N1 serial link
//   (LSB first). The bridge turns them into single 32-bit bus writes or reads,
//   stalls the CPU with `hold` while it owns the bus, and answers over `tx`.
//
//   Packets (multibyte fields LSB first):
//     0x57 A0..A3 D0..D3 -> bus write, answer 0x06
//     0x52 A0..A3        -> bus read,  answer D0..D3
//     0x50               -> ping,      answer 0x06
//     anything else      -> answer 0x15
//
//   Ports:
//     clk        system clock
//     rst_n      synchronous active-low reset
//     rx         serial input (asynchronous, idle high)
//     tx         serial output (idle high)
//     bus_cs     bus select
//     bus_ren    read strobe, one-cycle pulse
//     bus_wen    write strobe, one-cycle pulse
//     bus_addr   32-bit byte address
//     bus_wdata  32-bit write data
//     bus_rdata  32-bit read data, valid RD_LAT cycles after bus_ren
//     hold       CPU stall request while the bridge owns the bus
//     frame_err  one-cycle pulse when a stop bit is sampled low
//
//   Optional feature: define UART_BRIDGE_TIMEOUT_EN to abort a partial packet
//   (answering 0x15) when no byte arrives for TIMEOUT_CYC cycles.

module uart_bus_bridge #(
  parameter int CLK_DIV     = 87,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        bus_cs,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        hold,
  output logic        frame_err
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  // ---------------- RX engine ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t     rx_state;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic [7:0]    rx_data;

  // After the mid-start check the counter restarts, so each later sample at
  // LAST lands in the middle of its bit. After a bad stop bit we wait for the
  // line to return high so the remainder of the low stop bit is not taken as
  // a new start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
              rx_state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX engine ----------------
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic [8:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  // tx_bit counts the bit currently on the line (0 = start, 9 = stop).
  // The shift register carries the data bits followed by the stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx       <= 1'b0;
        tx_shift <= {1'b1, tx_byte};
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_busy  <= 1'b1;
      end
    end else if (tx_cnt == LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bit   <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // ---------------- Packet FSM ----------------
  typedef enum logic [2:0] {
    P_IDLE, P_ADDR, P_DATA, P_BUS_WR, P_BUS_RD, P_RD_WAIT, P_RESP, P_NAK
  } pkt_state_t;

  pkt_state_t  state, state_nxt;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [1:0]  wait_cnt;
  logic [31:0] resp_buf;
  logic [2:0]  resp_len;
  logic [2:0]  resp_sent;
  logic [2:0]  send_len;
  logic        timeout;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Idle-gap counter, only running while a packet is partially received.
  always_ff @(posedge clk) begin
    if (!rst_n || rx_valid || !(state == P_ADDR || state == P_DATA)) begin
      to_cnt <= '0;
    end else if (!timeout) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign timeout = (to_cnt == TW'(TIMEOUT_CYC));
`else
  // Without the feature a partial packet waits forever.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= P_IDLE;
    else        state <= state_nxt;
  end

  // Bus strobes and hold are decoded from the state: each bus state lasts
  // exactly one cycle, which gives the one-cycle strobe pulses.
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_byte   = resp_buf[7:0];
    send_len  = resp_len;
    bus_cs    = 1'b0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;
    hold      = 1'b0;
    case (state)
      P_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h57, 8'h52: state_nxt = P_ADDR;
            8'h50:        state_nxt = P_RESP;
            default:      state_nxt = P_NAK;
          endcase
        end
      end
      P_ADDR: begin
        if (timeout)                           state_nxt = P_NAK;
        else if (rx_valid && byte_cnt == 2'd3) state_nxt = is_write ? P_DATA : P_BUS_RD;
      end
      P_DATA: begin
        if (timeout)                           state_nxt = P_NAK;
        else if (rx_valid && byte_cnt == 2'd3) state_nxt = P_BUS_WR;
      end
      P_BUS_WR: begin
        bus_cs    = 1'b1;
        bus_wen   = 1'b1;
        hold      = 1'b1;
        state_nxt = P_RESP;
      end
      P_BUS_RD: begin
        bus_cs    = 1'b1;
        bus_ren   = 1'b1;
        hold      = 1'b1;
        state_nxt = P_RD_WAIT;
      end
      P_RD_WAIT: begin
        hold = 1'b1;
        if (wait_cnt == 2'(RD_LAT)) state_nxt = P_RESP;
      end
      P_RESP, P_NAK: begin
        if (state == P_NAK) begin
          tx_byte  = 8'h15;
          send_len = 3'd1;
        end
        if (resp_sent != send_len) begin
          tx_start = !tx_busy;
        end else if (!tx_busy) begin
          state_nxt = P_IDLE;
        end
      end
      default: state_nxt = P_IDLE;
    endcase
  end

  // Packet datapath. Address and data bytes shift in from the top so that
  // after four LSB-first bytes the word is assembled in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      resp_buf  <= '0;
      resp_len  <= '0;
      resp_sent <= '0;
    end else begin
      case (state)
        P_IDLE: begin
          byte_cnt  <= '0;
          resp_sent <= '0;
          if (rx_valid) begin
            is_write <= (rx_data == 8'h57);
            resp_buf <= 32'h0000_0006;
            resp_len <= 3'd1;
          end
        end
        P_ADDR: begin
          if (rx_valid) begin
            bus_addr <= {rx_data, bus_addr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        P_DATA: begin
          if (rx_valid) begin
            bus_wdata <= {rx_data, bus_wdata[31:8]};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        P_BUS_RD: wait_cnt <= 2'd1;
        P_RD_WAIT: begin
          if (wait_cnt == 2'(RD_LAT)) begin
            resp_buf <= bus_rdata;
            resp_len <= 3'd4;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        P_RESP, P_NAK: begin
          if (tx_start) begin
            resp_sent <= resp_sent + 3'd1;
            resp_buf  <= {8'h00, resp_buf[31:8]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge
//   Scoreboard bench for uart_bus_bridge. Stimulus pushes expected TX bytes,
//   bus accesses and hold lengths into queues; independent monitors decode
//   the serial output, watch the bus strobes and measure hold, and compare
//   against the queue heads.

module tb_uart_bus_bridge;

  localparam int CLK_DIV = 16;
  localparam int RD_LAT  = 1;
  localparam int TO_CYC  = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        bus_cs, bus_ren, bus_wen, hold, frame_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic [7:0] tx_q[$];
  bus_exp_t   bus_q[$];
  int         hold_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fe   = 0;
  int fe_rises = 0;
  int fe_cycles = 0;

  logic [31:0] mem [logic [31:0]];

  uart_bus_bridge #(
    .CLK_DIV    (CLK_DIV),
    .RD_LAT     (RD_LAT),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .tx       (tx),
    .bus_cs   (bus_cs),
    .bus_ren  (bus_ren),
    .bus_wen  (bus_wen),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .hold     (hold),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Memory model with one cycle of read latency.
  always @(posedge clk) begin
    if (bus_cs && bus_wen) mem[bus_addr] = bus_wdata;
    if (bus_cs && bus_ren) bus_rdata <= mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one serial frame; stop_bit = 0 produces a framing error.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CLK_DIV) @(posedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Bytes are packed first-byte-in-bits-[7:0].
  task automatic sendPacket(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) applyStimulus(bytes[8*i +: 8], 1'b1);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0 || hold_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", 32'(n < budget), 32'd1);
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  // Serial decoder on tx; frames overlapped by reset are discarded.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       aborted;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        aborted = 1'b0;
        for (int k = 0; k < CLK_DIV / 2; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (tx !== 1'b0) aborted = 1'b1;
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < CLK_DIV; k++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
          end
          b[i] = tx;
        end
        for (int k = 0; k < CLK_DIV; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        stop_bit = tx;
        if (!aborted) begin
          checkOutput("tx_stop_bit", 32'(stop_bit), 32'd1);
          checkOutput("tx_byte_expected", 32'(tx_q.size() > 0), 32'd1);
          if (tx_q.size() > 0) checkOutput("tx_byte", 32'(b), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  // Bus strobe monitor.
  initial begin : bus_monitor
    bus_exp_t e;
    forever begin
      @(negedge clk);
      if (bus_wen || bus_ren) begin
        checkOutput("bus_strobe_expected", 32'(bus_q.size() > 0), 32'd1);
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          checkOutput("bus_cs", 32'(bus_cs), 32'd1);
          checkOutput("bus_wen", 32'(bus_wen), 32'(e.is_wr));
          checkOutput("bus_ren", 32'(bus_ren), 32'(!e.is_wr));
          checkOutput("bus_addr", bus_addr, e.addr);
          if (e.is_wr) checkOutput("bus_wdata", bus_wdata, e.wdata);
          checkOutput("hold_at_strobe", 32'(hold), 32'd1);
        end
      end
    end
  end

  // Hold length monitor.
  initial begin : hold_monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (hold) begin
        run++;
      end else if (run > 0) begin
        checkOutput("hold_expected", 32'(hold_q.size() > 0), 32'd1);
        if (hold_q.size() > 0) checkOutput("hold_cycles", 32'(run), 32'(hold_q.pop_front()));
        run = 0;
      end
    end
  end

  // Frame error pulse monitor.
  initial begin : fe_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) fe_cycles++;
      if (frame_err && !prev) fe_rises++;
      prev = frame_err;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    // Power-on reset.
    repeat (5) @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_bus_cs", 32'(bus_cs), 32'd0);
    checkOutput("rst_bus_ren", 32'(bus_ren), 32'd0);
    checkOutput("rst_bus_wen", 32'(bus_wen), 32'd0);
    checkOutput("rst_hold", 32'(hold), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ping, then reset in the middle of its response frame.
    sendPacket(72'h50, 1);
    n = 0;
    while (tx !== 1'b0 && n < 20 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ping_resp_started", 32'(tx), 32'd0);
    repeat (3 * CLK_DIV) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midframe_rst_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("midframe_rst_cs", 32'(bus_cs), 32'd0);
    checkOutput("midframe_rst_hold", 32'(hold), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ping after reset.
    tx_q.push_back(8'h06);
    sendPacket(72'h50, 1);
    waitDrain(60 * CLK_DIV);

    // Write 0xDEADBEEF to 0x00000010.
    tx_q.push_back(8'h06);
    bus_q.push_back('{is_wr: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF});
    hold_q.push_back(1);
    sendPacket(72'hDE_AD_BE_EF_00_00_00_10_57, 9);
    waitDrain(60 * CLK_DIV);

    // Read 0x00000010 back.
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hAD);
    tx_q.push_back(8'hDE);
    bus_q.push_back('{is_wr: 1'b0, addr: 32'h0000_0010, wdata: 32'h0});
    hold_q.push_back(1 + RD_LAT);
    sendPacket(72'h00_00_00_10_52, 5);
    waitDrain(60 * CLK_DIV);

    // Write and read back a second pattern at a high address.
    tx_q.push_back(8'h06);
    bus_q.push_back('{is_wr: 1'b1, addr: 32'h8000_0004, wdata: 32'h1234_5678});
    hold_q.push_back(1);
    sendPacket(72'h12_34_56_78_80_00_00_04_57, 9);
    waitDrain(60 * CLK_DIV);
    tx_q.push_back(8'h78);
    tx_q.push_back(8'h56);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h12);
    bus_q.push_back('{is_wr: 1'b0, addr: 32'h8000_0004, wdata: 32'h0});
    hold_q.push_back(1 + RD_LAT);
    sendPacket(72'h80_00_00_04_52, 5);
    waitDrain(60 * CLK_DIV);

    // Unknown command.
    tx_q.push_back(8'h15);
    sendPacket(72'h41, 1);
    waitDrain(60 * CLK_DIV);

    // Bad stop bit: byte dropped, then a normal ping.
    exp_fe++;
    applyStimulus(8'h50, 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    tx_q.push_back(8'h06);
    sendPacket(72'h50, 1);
    waitDrain(60 * CLK_DIV);

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Partial write followed by silence.
    tx_q.push_back(8'h15);
    sendPacket(72'h10_57, 2);
    waitDrain(TO_CYC + 40 * CLK_DIV);
`endif

    checkOutput("frame_err_pulses", 32'(fe_rises), 32'(exp_fe));
    checkOutput("frame_err_width", 32'(fe_cycles), 32'(exp_fe));
    checkOutput("tx_q_empty", 32'(tx_q.size()), 32'd0);
    checkOutput("bus_q_empty", 32'(bus_q.size()), 32'd0);
    checkOutput("hold_q_empty", 32'(hold_q.size()), 32'd0);
    checkOutput("final_hold", 32'(hold), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
